// File: rtl/iob2axi_dma.sv
// iob2axi_dma: moves a programmed word count between a native port and AXI4 in 4 KB-safe INCR bursts.
module iob2axi_dma #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int AXI_LEN_W   = 8,
  parameter int FIFO_ADDR_W = 4,
  parameter int LEN_W       = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                run,
  input  logic                direction,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [LEN_W-1:0]    length,
  output logic                ready,
  output logic                error,
  output logic [LEN_W-1:0]    remaining,
  input  logic                s_valid,
  input  logic [DATA_W-1:0]   s_wdata,
  input  logic [DATA_W/8-1:0] s_wstrb,
  output logic [DATA_W-1:0]   s_rdata,
  output logic                s_ready,
  output logic [ADDR_W-1:0]   m_axi_awaddr,
  output logic [7:0]          m_axi_awlen,
  output logic [2:0]          m_axi_awsize,
  output logic [1:0]          m_axi_awburst,
  output logic                m_axi_awvalid,
  input  logic                m_axi_awready,
  output logic [DATA_W-1:0]   m_axi_wdata,
  output logic [DATA_W/8-1:0] m_axi_wstrb,
  output logic                m_axi_wlast,
  output logic                m_axi_wvalid,
  input  logic                m_axi_wready,
  input  logic [1:0]          m_axi_bresp,
  input  logic                m_axi_bvalid,
  output logic                m_axi_bready,
  output logic [ADDR_W-1:0]   m_axi_araddr,
  output logic [7:0]          m_axi_arlen,
  output logic [2:0]          m_axi_arsize,
  output logic [1:0]          m_axi_arburst,
  output logic                m_axi_arvalid,
  input  logic                m_axi_arready,
  input  logic [DATA_W-1:0]   m_axi_rdata,
  input  logic [1:0]          m_axi_rresp,
  input  logic                m_axi_rlast,
  input  logic                m_axi_rvalid,
  output logic                m_axi_rready
);
  localparam int SZ = $clog2(DATA_W/8);
  localparam int MX = (LEN_W > AXI_LEN_W) ? LEN_W : AXI_LEN_W;
  localparam int MY = (FIFO_ADDR_W > 13) ? FIFO_ADDR_W : 13;
  localparam int BW = ((MX > MY) ? MX : MY) + 1;
  localparam logic [BW-1:0] LIM_AXI = BW'(2**AXI_LEN_W);
  localparam logic [BW-1:0] LIM_FIFO = BW'(2**FIFO_ADDR_W);
  localparam logic [FIFO_ADDR_W:0] DEPTH = {1'b1, {FIFO_ADDR_W{1'b0}}};
  typedef enum logic [2:0] {IDLE, WAIT, ADDR, DATA, RESP} state_t;
  state_t state, nxt;
  logic dir_q;
  logic [ADDR_W-1:0] addr_cur;
  logic [7:0] len_q, cnt;
  logic [FIFO_ADDR_W:0] in_wp, in_rp, out_wp, out_rp, in_lvl, out_free;
  logic [DATA_W-1:0] in_mem [2**FIFO_ADDR_W];
  logic [DATA_W-1:0] out_mem [2**FIFO_ADDR_W];
  logic [BW-1:0] bnd, m1, m2, blen;
  logic push, pop, start, a_hs, w_hs, r_hs, b_hs, fits, done;
  assign in_lvl = in_wp - in_rp;
  assign out_free = DEPTH - (out_wp - out_rp);
  assign push = s_valid & |s_wstrb & ~in_lvl[FIFO_ADDR_W];
  assign pop = s_valid & ~|s_wstrb & (out_wp != out_rp);
  assign s_ready = push | pop;
  assign s_rdata = out_mem[out_rp[FIFO_ADDR_W-1:0]];
  // burst length: the tightest of words left, AXI limit, FIFO depth and distance to the 4 KB page end
  assign bnd = BW'((13'h1000 - {1'b0, addr_cur[11:0]}) >> SZ);
  assign m1 = (BW'(remaining) < LIM_AXI) ? BW'(remaining) : LIM_AXI;
  assign m2 = (m1 < LIM_FIFO) ? m1 : LIM_FIFO;
  assign blen = (m2 < bnd) ? m2 : bnd;
  assign start = run & (state == IDLE);
  assign a_hs = (m_axi_awvalid & m_axi_awready) | (m_axi_arvalid & m_axi_arready);
  assign w_hs = m_axi_wvalid & m_axi_wready;
  assign r_hs = m_axi_rvalid & m_axi_rready;
  assign b_hs = m_axi_bvalid & m_axi_bready;
  assign fits = dir_q ? (BW'(in_lvl) >= blen) : (BW'(out_free) >= blen);
  assign done = remaining == '0;
  assign ready = state == IDLE;
  assign m_axi_awaddr = addr_cur;
  assign m_axi_awlen = len_q;
  assign m_axi_awsize = 3'(SZ);
  assign m_axi_awburst = 2'b01;
  assign m_axi_awvalid = (state == ADDR) & dir_q;
  assign m_axi_wdata = in_mem[in_rp[FIFO_ADDR_W-1:0]];
  assign m_axi_wstrb = '1;
  assign m_axi_wlast = cnt == len_q;
  assign m_axi_wvalid = (state == DATA) & dir_q;
  assign m_axi_bready = (state == RESP) & dir_q;
  assign m_axi_araddr = addr_cur;
  assign m_axi_arlen = len_q;
  assign m_axi_arsize = 3'(SZ);
  assign m_axi_arburst = 2'b01;
  assign m_axi_arvalid = (state == ADDR) & ~dir_q;
  assign m_axi_rready = (state == DATA) & ~dir_q;
  always_comb begin
    nxt = state;
    case (state)
      IDLE: nxt = (run && length != '0) ? WAIT : IDLE;
      WAIT: nxt = fits ? ADDR : WAIT;
      ADDR: nxt = a_hs ? DATA : ADDR;
      DATA: if (dir_q ? (w_hs & m_axi_wlast) : (r_hs & m_axi_rlast)) nxt = dir_q ? RESP : (done ? IDLE : WAIT);
      RESP: nxt = b_hs ? (done ? IDLE : WAIT) : RESP;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= nxt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dir_q <= 1'b0;
      addr_cur <= '0;
      remaining <= '0;
      error <= 1'b0;
      len_q <= '0;
      cnt <= '0;
      in_wp <= '0;
      in_rp <= '0;
      out_wp <= '0;
      out_rp <= '0;
    end else begin
      if (push) in_wp <= in_wp + 1'b1;
      if (w_hs) in_rp <= in_rp + 1'b1;
      if (r_hs) out_wp <= out_wp + 1'b1;
      if (pop) out_rp <= out_rp + 1'b1;
      if (start) begin
        dir_q <= direction;
        addr_cur <= addr;
        remaining <= length;
      end
      if (state == WAIT && fits) len_q <= 8'(blen - 1'b1);
      if (a_hs) begin
        remaining <= remaining - LEN_W'(blen);
        addr_cur <= addr_cur + (ADDR_W'(blen) << SZ);
      end
      cnt <= a_hs ? '0 : (w_hs ? cnt + 1'b1 : cnt);
      error <= ~start & (error | (b_hs & |m_axi_bresp) | (r_hs & |m_axi_rresp));
    end
  end
  always_ff @(posedge clk) begin
    if (push) in_mem[in_wp[FIFO_ADDR_W-1:0]] <= s_wdata;
    if (r_hs) out_mem[out_wp[FIFO_ADDR_W-1:0]] <= m_axi_rdata;
  end
endmodule

// File: doc/iob2axi_dma.md
Name: iob2axi_dma

Overview:
Parametrised successor of the native-to-AXI4 bridge. It moves a programmed number of words between the native slave port and AXI4 memory, in either direction. Transfers are split internally into INCR bursts, each bounded by max burst length, FIFO occupancy/space and 4 KB boundaries. It sits between an accelerator's native data port and the system AXI interconnect, with one outstanding burst at a time.

Parameters:
ADDR_W, 32, byte address width (native and AXI)
DATA_W, 32, data width; power of 2, 8..1024
AXI_LEN_W, 8, AXI len field width; max burst = 2^AXI_LEN_W beats
FIFO_ADDR_W, 4, log2 of internal FIFO depth in words
LEN_W, 16, width of total transfer length in words

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
run  in  1  start pulse; sampled only when ready=1
direction  in  1  0 = AXI read to native, 1 = native to AXI write
addr  in  ADDR_W  start byte address, word-aligned
length  in  LEN_W  total words to move
ready  out  1  idle, previous transfer complete
error  out  1  sticky: some BRESP/RRESP != OKAY since last run
remaining  out  LEN_W  words not yet issued in AXI bursts
s_valid  in  1  native request
s_wdata  in  DATA_W  write data (direction=1)
s_wstrb  in  DATA_W/8  nonzero = push, zero = pop
s_rdata  out  DATA_W  read data, valid while s_ready=1 on a pop
s_ready  out  1  request accepted this cycle (combinational)
m_axi_aw*  out  awaddr ADDR_W, awlen 8, awsize 3, awburst 2, awvalid 1; in awready 1
m_axi_w*  out  wdata DATA_W, wstrb DATA_W/8, wlast 1, wvalid 1; in wready 1
m_axi_b*  in  bresp 2, bvalid 1; out bready 1
m_axi_ar*  out  araddr ADDR_W, arlen 8, arsize 3, arburst 2, arvalid 1; in arready 1
m_axi_r*  in  rdata DATA_W, rresp 2, rlast 1, rvalid 1; out rready 1

Behaviour:
- Reset values: ready=1, error=0, remaining=0, s_ready=0, all AXI valid/ready outputs 0, FIFOs empty.
- FIFOs: two synchronous first-word-fall-through FIFOs, depth 2^FIFO_ADDR_W.
  - Input FIFO feeds the W channel.
  - Output FIFO is filled from the R channel.
- Native handshake:
  - Push: s_ready = s_valid & |s_wstrb & ~in_full; the word is written on that edge.
  - Pop: s_ready = s_valid & ~|s_wstrb & ~out_empty; s_rdata = output FIFO head in the same cycle.
  - The native port is usable in any state, including while ready=1.
- Start:
  - run & ready: latch addr and length, set remaining=length, clear error.
  - If length=0, ready stays 1 and no AXI traffic occurs.
  - Otherwise ready drops in the next cycle.
  - run while ready=0 is ignored.
- Burst size: blen = min(remaining, 2^AXI_LEN_W, 2^FIFO_ADDR_W, words to next 4 KB boundary).
  - Words to boundary = (4096 - addr_cur[11:0]) >> log2(DATA_W/8).
  - Compute in LEN_W+1 bits; no truncation.
- FSM states: IDLE, WAIT, ADDR, DATA, RESP.
  - WAIT → ADDR when the data path can carry the whole burst: write needs in_level >= blen; read needs out_free >= blen.
  - ADDR: hold a*valid; awlen/arlen = blen-1; a*size = log2(DATA_W/8); a*burst = 2'b01.
    - On a*ready: remaining -= blen, addr_cur += blen*DATA_W/8, go to DATA.
  - DATA, write: wvalid = 1; each beat pops the input FIFO; wlast on beat blen. After the last beat go to RESP.
  - DATA, read: rready = 1 (space is guaranteed); each beat pushes the output FIFO. On rlast go to IDLE if remaining=0, else WAIT.
  - RESP: bready = 1; on bvalid go to IDLE if remaining=0, else WAIT.
- Error: error |= (bresp != 0) on each B handshake and (rresp != 0) on each R beat. The transfer continues regardless.
- ready = 1 in IDLE only.
  - Write: complete after the final B response.
  - Read: complete after the final R beat; data may still sit in the output FIFO.
- Unused AXI channel of the inactive direction: valids and readies held at 0.
- Reset mid-operation: immediate return to reset values; FIFOs flushed; in-flight AXI bursts abandoned.

Test Plan:
- DATA_W=32, FIFO_ADDR_W=4, write 8 words to 0x0000: push 8 words, run → one AW with awlen=7, 8 W beats, wlast on 8th; ready=1 after bvalid; remaining=0.
- Write 20 words from 0x0FF8, FIFO_ADDR_W=5: bursts awaddr 0x0FF8 awlen=1, then 0x1000 awlen=17; no burst crosses 4 KB.
- FIFO_ADDR_W=8, read 300 words from 0x2000: arlen=255 then arlen=43; popping 300 times returns the slave pattern in order; no R stall (rready stays 1).
- Write 32 words in 2 bursts, second bresp=2'b10: error=1 at completion with ready=1; next run clears error.
- run with length=0: ready never drops; no AXI valid asserted; pop on empty FIFO gives s_ready=0.
- rst asserted mid-burst in DATA: next cycle all valids 0, ready=1, remaining=0; a new 4-word write then completes normally.
